// File: rtl/mem_request_arbiter.sv
// Two-requester (instruction/data) memory arbiter with per-grant timeout.
// Define MEM_ARB_FAIRNESS_EN for alternating priority; default is fixed data priority.
module mem_request_arbiter #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd200
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic [1:0]  ramstate,
  input  logic [31:0] ramload,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        ramREN,
  output logic        ramWEN,
  output logic        timeout
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;
  // FREE, BUSY and ERROR all hold the grant; only ACCESS completes it.
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

  state_t        state;
  state_t        next_state;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_store;
  logic          lat_ren;
  logic          lat_wen;
  logic [CW-1:0] wait_cnt;
  logic          in_grant;
  logic          access;
  logic          dropped;
  logic          expired;
  logic          d_pending;
  logic          pick_data;

  assign in_grant  = (state != IDLE);
  assign access    = in_grant && (ramstate == RAM_ACCESS);
  assign dropped   = ((state == IGRANT) && !iREN) ||
                     ((state == DGRANT) && !dREN && !dWEN);
  assign expired   = in_grant && (CW'(wait_cnt + CW'(1)) == TIMEOUT_CYCLES);
  assign d_pending = dREN || dWEN;

`ifdef MEM_ARB_FAIRNESS_EN
  logic last_was_data;

  // Remembers which side completed last so a contended IDLE favours the other.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last_was_data <= 1'b0;
    end else if (access) begin
      last_was_data <= (state == DGRANT);
    end
  end

  assign pick_data = d_pending && !(iREN && last_was_data);
`else
  assign pick_data = d_pending;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Completion beats an abandoned request, which beats a timeout.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (pick_data) begin
          next_state = DGRANT;
        end else if (iREN) begin
          next_state = IGRANT;
        end
      end
      IGRANT, DGRANT: begin
        if (access || dropped || expired) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramaddr  = '0;
    ramstore = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    case (state)
      IGRANT, DGRANT: begin
        ramaddr  = lat_addr;
        ramstore = lat_store;
        ramREN   = lat_ren;
        ramWEN   = lat_wen;
        if (ramstate == RAM_ACCESS) begin
          if (state == IGRANT) begin
            iwait = 1'b0;
            iload = ramload;
          end else begin
            dwait = 1'b0;
            dload = ramload;
          end
        end
      end
      default: ;
    endcase
  end

  // Request capture on grant entry, wait counting, and the timeout pulse.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      lat_addr  <= '0;
      lat_store <= '0;
      lat_ren   <= 1'b0;
      lat_wen   <= 1'b0;
      wait_cnt  <= '0;
      timeout   <= 1'b0;
    end else begin
      timeout <= in_grant && !access && !dropped && expired;
      if (!in_grant && (next_state == DGRANT)) begin
        lat_addr  <= daddr;
        lat_store <= dstore;
        lat_ren   <= dREN && !dWEN;
        lat_wen   <= dWEN;
        wait_cnt  <= '0;
      end else if (!in_grant && (next_state == IGRANT)) begin
        lat_addr  <= iaddr;
        lat_store <= '0;
        lat_ren   <= 1'b1;
        lat_wen   <= 1'b0;
        wait_cnt  <= '0;
      end else if (next_state == IDLE) begin
        lat_addr  <= '0;
        lat_store <= '0;
        lat_ren   <= 1'b0;
        lat_wen   <= 1'b0;
        wait_cnt  <= '0;
      end else begin
        wait_cnt <= CW'(wait_cnt + CW'(1));
      end
    end
  end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Randomized bench for mem_request_arbiter against a transaction-level model of the grant rules.
module tb_mem_request_arbiter;

  localparam int TMO = 4;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, timeout;
  logic [31:0] iload, dload, ramaddr, ramstore;

  mem_request_arbiter #(.TIMEOUT_CYCLES(8'(TMO))) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .ramstate(ramstate), .ramload(ramload),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  // Model: who currently owns the RAM (0 none, 1 instruction, 2 data) and what it asked for.
  int          m_owner;
  logic [31:0] m_addr, m_store;
  bit          m_rd, m_wr, m_tmo, m_last_data;
  int          m_waited;
  int          n_checks, n_err, n_done, n_tmo, n_igrant;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_addr = '0; m_store = '0; m_rd = 0; m_wr = 0;
    m_tmo = 0; m_last_data = 0; m_waited = 0;
  endtask

  task automatic check_outputs();
    bit acc;
    acc = (m_owner != 0) && (ramstate == RS_ACCESS);
    check_eq("ramREN", 32'(ramREN),
             (m_owner == 1) ? 32'd1 : (m_owner == 2) ? 32'(m_rd) : 32'd0);
    check_eq("ramWEN", 32'(ramWEN), (m_owner == 2) ? 32'(m_wr) : 32'd0);
    check_eq("ramaddr", ramaddr, (m_owner != 0) ? m_addr : 32'd0);
    check_eq("ramstore", ramstore, (m_owner != 0) ? m_store : 32'd0);
    check_eq("iwait", 32'(iwait), (m_owner == 1 && acc) ? 32'd0 : 32'd1);
    check_eq("dwait", 32'(dwait), (m_owner == 2 && acc) ? 32'd0 : 32'd1);
    check_eq("iload", iload, (m_owner == 1 && acc) ? ramload : 32'd0);
    check_eq("dload", dload, (m_owner == 2 && acc) ? ramload : 32'd0);
    check_eq("timeout", 32'(timeout), 32'(m_tmo));
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    bit acc, want_d, new_tmo;
    new_tmo = 0;
    acc = (m_owner != 0) && (ramstate == RS_ACCESS);
    want_d = dREN || dWEN;
`ifdef MEM_ARB_FAIRNESS_EN
    if (iREN && m_last_data) want_d = 0;
`endif
    if (m_owner == 0) begin
      m_waited = 0;
      if (want_d) begin
        m_owner = 2; m_addr = daddr; m_store = dstore; m_wr = dWEN; m_rd = dREN && !dWEN;
      end else if (iREN) begin
        m_owner = 1; m_addr = iaddr; m_store = 0; m_rd = 1; m_wr = 0;
        n_igrant++;
      end
    end else if (acc) begin
      m_last_data = (m_owner == 2);
      m_owner = 0;
      n_done++;
    end else if ((m_owner == 1 && !iREN) || (m_owner == 2 && !dREN && !dWEN)) begin
      m_owner = 0;
    end else begin
      m_waited++;
      if (m_waited >= TMO) begin
        m_owner = 0;
        new_tmo = 1;
        n_tmo++;
      end
    end
    m_tmo = new_tmo;
  endtask

  task automatic step();
    #1;
    check_outputs();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic randomize_data();
    iaddr   = $urandom;
    daddr   = $urandom;
    dstore  = $urandom;
    ramload = $urandom;
  endtask

  task automatic random_ramstate();
    int r;
    r = $urandom_range(0, 9);
    ramstate = (r < 2) ? RS_ACCESS : (r < 4) ? 2'd0 : (r < 5) ? 2'd3 : RS_BUSY;
  endtask

  initial begin
    int guard;
    n_checks = 0; n_err = 0; n_done = 0; n_tmo = 0; n_igrant = 0;
    model_reset();
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0; ramstate = RS_ACCESS;
    randomize_data();
    repeat (3) @(posedge CLK);
    #1;
    step();
    nRST = 1'b1;

    // Free-running random traffic with sticky enables.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) iREN = ~iREN;
      if ($urandom_range(0, 5) == 0) dREN = ~dREN;
      if ($urandom_range(0, 7) == 0) dWEN = ~dWEN;
      randomize_data();
      random_ramstate();
      step();
    end

    // Both sides requesting continuously.
    iREN = 1; dREN = 1; dWEN = 0;
    for (int c = 0; c < 300; c++) begin
      randomize_data();
      random_ramstate();
      step();
    end

    // Abort a data write mid-grant with an asynchronous reset.
    iREN = 0; dREN = 0; dWEN = 0; ramstate = RS_BUSY;
    guard = 0;
    while (m_owner != 0 && guard < 20) begin
      step();
      guard++;
    end
    check_eq("idle_before_abort", 32'(m_owner), 32'd0);
    dWEN = 1; daddr = 32'h0000_0200; dstore = 32'hDEAD_BEEF;
    step();
    step();
    #1;
    check_outputs();
    ramstate = RS_ACCESS;
    nRST = 1'b0;
    #1;
    check_eq("abort_ramWEN", 32'(ramWEN), 32'd0);
    check_eq("abort_ramREN", 32'(ramREN), 32'd0);
    check_eq("abort_dwait", 32'(dwait), 32'd1);
    check_eq("abort_dload", dload, 32'd0);
    model_reset();
    dWEN = 0;
    @(posedge CLK);
    #1;
    step();
    nRST = 1'b1;

    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 5) == 0) iREN = ~iREN;
      if ($urandom_range(0, 5) == 0) dREN = ~dREN;
      if ($urandom_range(0, 7) == 0) dWEN = ~dWEN;
      randomize_data();
      random_ramstate();
      step();
    end

    check_eq("completions_seen", 32'(n_done > 0), 32'd1);
    check_eq("timeouts_seen", 32'(n_tmo > 0), 32'd1);
    check_eq("igrants_seen", 32'(n_igrant > 0), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mem_request_arbiter.md
MEM_REQUEST_ARBITER -- requirements
Module: mem_request_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 8'd200, the maximum cycles a grant waits for ramstate==ACCESS.
REQ-002 The block SHALL have the following ports, listed one per line:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous reset, active low.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction address.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32  data address.
- dstore  in  32  data write value.
- ramstate  in  2  ramstate_t (FREE, BUSY, ACCESS, ERROR).
- ramload  in  32  RAM read data.
- iwait  out  1  instruction stall.
- dwait  out  1  data stall.
- iload  out  32  instruction return data.
- dload  out  32  data return data.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- timeout  out  1  one-cycle pulse on grant timeout.
REQ-003 The block SHALL use the single clock CLK, and nRST SHALL be asynchronous and active low.

Function
REQ-004 The FSM SHALL have states IDLE, IGRANT and DGRANT, held in a registered state variable.
REQ-005 In IDLE, if dREN or dWEN is high, the next state SHALL be DGRANT; otherwise, if iREN is high, it SHALL be IGRANT; otherwise it SHALL stay IDLE.
REQ-006 On entry to a grant state, the block SHALL latch the address, the store data and the operation (read or write) into registers; RAM outputs SHALL be driven only from these latched values.
REQ-007 In IGRANT, ramREN SHALL be 1; in DGRANT, ramREN SHALL equal the latched dREN and ramWEN SHALL equal the latched dWEN.
REQ-008 In IDLE, ramREN, ramWEN, ramaddr and ramstore SHALL all be 0.
REQ-009 If dREN and dWEN are both high, the operation SHALL be treated as a write, with ramREN=0.
REQ-010 iwait SHALL be 1 unless the state is IGRANT and ramstate==ACCESS; dwait SHALL follow the same rule for DGRANT.
REQ-011 iload and dload SHALL equal ramload combinationally during their own ACCESS cycle, and SHALL be 0 otherwise.
REQ-012 ramstate==ACCESS in a grant state SHALL cause a return to IDLE on the next edge, giving a minimum request-to-completion latency of 2 cycles.
REQ-013 ramstate values BUSY and FREE SHALL hold the grant; ERROR SHALL hold the grant and re-issue the same access the next cycle.
REQ-014 If the granted requester drops its enable before ACCESS (iREN=0 in IGRANT, or dREN=dWEN=0 in DGRANT), the block SHALL return to IDLE on the next edge without completing; wait stays 1.
REQ-015 An 8-bit wait counter SHALL clear on grant entry and increment each grant cycle without ACCESS.
REQ-016 When the wait counter reaches TIMEOUT_CYCLES, the block SHALL pulse timeout for 1 cycle and return to IDLE; the wait output stays 1, and the request re-arbitrates.
REQ-017 A request arriving during a grant SHALL be arbitrated only from IDLE; no back-to-back grant is allowed without one IDLE cycle.

Reset
REQ-018 nRST low SHALL force IDLE, clear the wait counter and the latched registers, set timeout=0, and set iwait=dwait=1.
REQ-019 Reset asserted mid-grant SHALL abort the access, with ramREN=ramWEN=0 immediately (asynchronously).

Configuration
REQ-020 Macro MEM_ARB_FAIRNESS_EN SHALL select the arbitration policy.
REQ-021 When MEM_ARB_FAIRNESS_EN is defined, a 1-bit last_was_data register (reset 0) SHALL record the last completed grant.
REQ-022 With MEM_ARB_FAIRNESS_EN defined, when both requesters are pending in IDLE and last_was_data=1, IGRANT SHALL win; otherwise DGRANT SHALL win.
REQ-023 When MEM_ARB_FAIRNESS_EN is undefined, fixed data priority (REQ-005) SHALL apply, and no last_was_data register SHALL exist.

Verification
REQ-024 Scenario: iREN=1, iaddr=0x0000_0040, ramstate=ACCESS on the second cycle with ramload=0x2402_0001 -> ramREN=1 and ramaddr=0x40 in cycle 2; iload=0x2402_0001 and iwait=0 in the same cycle; then IDLE.
REQ-025 Scenario: iREN=dREN=1 simultaneously, daddr=0x100 -> DGRANT first; iwait=1 throughout; IGRANT follows one IDLE cycle after dwait=0.
REQ-026 Scenario: dWEN=1, daddr=0x200, dstore=0xDEAD_BEEF, with ramstate BUSY for 3 cycles then ACCESS -> ramWEN=1 and ramstore=0xDEADBEEF held 4 cycles; dwait=0 only in the ACCESS cycle.
REQ-027 Scenario: DGRANT with ramstate held BUSY, TIMEOUT_CYCLES=4 -> timeout pulses 1 cycle after 4 non-ACCESS cycles; state goes to IDLE, then DGRANT is re-entered.
REQ-028 Scenario: nRST dropped mid-DGRANT -> ramWEN=0 asynchronously; state is IDLE on release; no dload is returned.
REQ-029 Scenario: with MEM_ARB_FAIRNESS_EN defined, iREN and dREN held continuously -> grants alternate D, I, D, I; without the macro -> D only, and iwait stays 1.
